// File: rtl/motor_ramp_if.sv
// Navigation-side / H-bridge-side signal bundle for motor_ramp_ctrl.
// The master modport belongs to the navigation FSM; the slave modport belongs to the controller.
interface motor_ramp_if #(
  parameter int unsigned DUTY_W = 10
);
  logic [4:0]        mode;
  logic [1:0]        pwm;
  logic [1:0]        l_IN;
  logic [1:0]        r_IN;
  logic [DUTY_W-1:0] left_duty;
  logic [DUTY_W-1:0] right_duty;
  logic              busy;

  modport master (
    output mode,
    input  pwm, l_IN, r_IN, left_duty, right_duty, busy
  );

  modport slave (
    input  mode,
    output pwm, l_IN, r_IN, left_duty, right_duty, busy
  );
endinterface

// File: rtl/motor_ramp_ctrl.sv
// Two-channel motor driver: mode decode, rate-limited duty ramp, reversal dead-time,
// and period-aligned PWM with an ERROR emergency stop.
module motor_ramp_ctrl #(
  parameter int unsigned DUTY_W     = 10,
  parameter int unsigned SPEED_FWD  = 800,
  parameter int unsigned SPEED_TURN = 750,
  parameter int unsigned RAMP_STEP  = 8,
  parameter int unsigned RAMP_DIV   = 1000,
  parameter int unsigned DEAD_CYC   = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  motor_ramp_if.slave bus
);

  localparam int unsigned PRE_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);
  localparam logic [DUTY_W-1:0] V_FWD     = DUTY_W'(SPEED_FWD);
  localparam logic [DUTY_W-1:0] V_TURN    = DUTY_W'(SPEED_TURN);
  localparam logic [DUTY_W-1:0] V_STEP    = DUTY_W'(RAMP_STEP);

  typedef enum logic [4:0] {
    MODE_IDLE     = 5'd0,
    MODE_START    = 5'd1,
    MODE_COUNT    = 5'd2,
    MODE_STRAIGHT = 5'd3,
    MODE_CHOOSE   = 5'd4,
    MODE_LEFT     = 5'd5,
    MODE_RIGHT    = 5'd6,
    MODE_BACK     = 5'd7,
    MODE_STOP     = 5'd30,
    MODE_ERROR    = 5'd31
  } mode_e;

  typedef enum logic {ST_RUN, ST_DEAD} ch_state_e;
  typedef enum logic {DIR_FWD, DIR_REV} dir_e;

  typedef struct packed {
    ch_state_e         st;
    dir_e              dir;
    logic [DUTY_W-1:0] duty;
    logic [DEAD_W-1:0] dead;
  } ch_t;

  ch_t               l_q, l_d, r_q, r_d;
  dir_e              l_tgt, r_tgt;
  logic [DUTY_W-1:0] tgt_spd, l_goal, r_goal;
  logic [DUTY_W-1:0] l_app_q, l_app_d, r_app_q, r_app_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [1:0]        pwm_q, pwm_d;
  logic              busy_q, busy_d;
  logic              tick, err;

  function automatic logic [1:0] ch_in(input ch_t ch);
    if (ch.st == ST_DEAD) return 2'b00;
    return (ch.dir == DIR_FWD) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [DUTY_W-1:0] ch_goal(input ch_t ch, input dir_e tdir,
                                                input logic [DUTY_W-1:0] spd);
    return (tdir == ch.dir) ? spd : '0;
  endfunction

  // Ramp compares before adding/subtracting, so the step can never wrap past the goal.
  function automatic ch_t ch_next(input ch_t ch, input dir_e tdir,
                                  input logic [DUTY_W-1:0] goal,
                                  input logic tk, input logic e);
    ch_t nx;
    nx      = ch;
    nx.dead = '0;
    unique case (ch.st)
      ST_RUN: begin
        if (e) begin
          nx.duty = '0;
        end else if (tk) begin
          if (ch.duty < goal)
            nx.duty = ((goal - ch.duty) > V_STEP) ? ch.duty + V_STEP : goal;
          else if (ch.duty > goal)
            nx.duty = ((ch.duty - goal) > V_STEP) ? ch.duty - V_STEP : goal;
        end
        if (ch.duty == '0 && tdir != ch.dir) nx.st = ST_DEAD;
      end
      ST_DEAD: begin
        nx.duty = '0;
        nx.dead = ch.dead + 1'b1;
        if (ch.dead == DEAD_LAST) begin
          nx.dir  = tdir;
          nx.st   = ST_RUN;
          nx.dead = '0;
        end
      end
      default: nx = ch;
    endcase
    return nx;
  endfunction

  // Non-motion codes keep the present direction so they never trigger a reversal.
  always_comb begin
    err     = (bus.mode == MODE_ERROR);
    tgt_spd = '0;
    l_tgt   = l_q.dir;
    r_tgt   = r_q.dir;
    case (bus.mode)
      MODE_STRAIGHT, MODE_CHOOSE: begin
        tgt_spd = V_FWD;  l_tgt = DIR_FWD; r_tgt = DIR_FWD;
      end
      MODE_LEFT: begin
        tgt_spd = V_TURN; l_tgt = DIR_REV; r_tgt = DIR_FWD;
      end
      MODE_RIGHT: begin
        tgt_spd = V_TURN; l_tgt = DIR_FWD; r_tgt = DIR_REV;
      end
      MODE_BACK: begin
        tgt_spd = V_TURN; l_tgt = DIR_REV; r_tgt = DIR_REV;
      end
      default: ;
    endcase
  end

  always_comb begin
    tick   = (pre_q == PRE_LAST);
    pre_d  = tick ? '0 : pre_q + 1'b1;
    cnt_d  = cnt_q + 1'b1;
    l_goal = ch_goal(l_q, l_tgt, tgt_spd);
    r_goal = ch_goal(r_q, r_tgt, tgt_spd);
    l_d    = ch_next(l_q, l_tgt, l_goal, tick, err);
    r_d    = ch_next(r_q, r_tgt, r_goal, tick, err);

    l_app_d = (cnt_q == '1) ? l_q.duty : l_app_q;
    r_app_d = (cnt_q == '1) ? r_q.duty : r_app_q;
    if (err) begin
      l_app_d = '0;
      r_app_d = '0;
    end

    pwm_d  = {!err && (cnt_q < l_app_q), !err && (cnt_q < r_app_q)};
    busy_d = (l_q.duty != l_goal) || (r_q.duty != r_goal) ||
             (l_q.st == ST_DEAD) || (r_q.st == ST_DEAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q     <= '{st: ST_RUN, dir: DIR_FWD, duty: '0, dead: '0};
      r_q     <= '{st: ST_RUN, dir: DIR_FWD, duty: '0, dead: '0};
      l_app_q <= '0;
      r_app_q <= '0;
      cnt_q   <= '0;
      pre_q   <= '0;
      pwm_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      l_q     <= l_d;
      r_q     <= r_d;
      l_app_q <= l_app_d;
      r_app_q <= r_app_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      pwm_q   <= pwm_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.pwm        = pwm_q;
  assign bus.l_IN       = ch_in(l_q);
  assign bus.r_IN       = ch_in(r_q);
  assign bus.left_duty  = l_q.duty;
  assign bus.right_duty = r_q.duty;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: expected duty/H-bridge event tables replayed through a queue,
// plus hand-written ERROR, PWM-ratio and reset-during-dead-time sequences.
`timescale 1ns/1ps
module tb_motor_ramp_ctrl;
  localparam int DW = 10;

  typedef struct packed {
    logic [DW-1:0] ld;
    logic [DW-1:0] rd;
    logic [1:0]    lin;
    logic [1:0]    rin;
  } evt_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  evt_t sb[$];
  int   evt_cyc[$];

  localparam logic [26:0] RST_VEC = {2'b00, 2'b10, 2'b10, 10'd0, 10'd0, 1'b0};

  motor_ramp_if #(.DUTY_W(DW)) bus ();
  motor_ramp_if #(.DUTY_W(DW)) bus2 ();

  motor_ramp_ctrl #(
    .DUTY_W(DW), .SPEED_FWD(800), .SPEED_TURN(750),
    .RAMP_STEP(100), .RAMP_DIV(4), .DEAD_CYC(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  motor_ramp_ctrl #(
    .DUTY_W(DW), .SPEED_FWD(512), .SPEED_TURN(750),
    .RAMP_STEP(100), .RAMP_DIV(4), .DEAD_CYC(8)
  ) u_dut512 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic evt_t mk(input int l, input int r, input logic [1:0] li, input logic [1:0] ri);
    evt_t e;
    e.ld = DW'(l); e.rd = DW'(r); e.lin = li; e.rin = ri;
    return e;
  endfunction

  function automatic evt_t cur();
    return mk(int'(bus.left_duty), int'(bus.right_duty), bus.l_IN, bus.r_IN);
  endfunction

  function automatic logic [26:0] outs();
    return {bus.pwm, bus.l_IN, bus.r_IN, bus.left_duty, bus.right_duty, bus.busy};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Each queued record is compared against the next change of duties/IN pins.
  task automatic drain(input string name, input int bound);
    evt_t prev, now, e;
    int   idx, w;
    evt_cyc.delete();
    prev = cur();
    idx  = 0;
    while (sb.size() > 0) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
        now = cur();
      end while (now == prev && w < bound);
      e = sb.pop_front();
      chk($sformatf("%s[%0d]", name, idx), 64'(now), 64'(e));
      evt_cyc.push_back(cyc);
      prev = now;
      idx++;
    end
  endtask

  task automatic busy_drop(input string name);
    chk({name, "_busy_hi"}, 64'(bus.busy), 64'(1'b1));
    @(negedge clk);
    chk({name, "_busy_lo"}, 64'(bus.busy), 64'(1'b0));
  endtask

  task automatic settle(input string name, input logic [4:0] m, input evt_t exp);
    int w, quiet;
    bus.mode = m;
    w = 0;
    quiet = 0;
    repeat (2) @(negedge clk);
    while (quiet < 4 && w < 400) begin
      @(negedge clk);
      w++;
      quiet = bus.busy ? 0 : quiet + 1;
    end
    chk(name, 64'(cur()), 64'(exp));
  endtask

  task automatic count_high(input bit use2, output int hl, output int hr);
    hl = 0;
    hr = 0;
    repeat (1024) begin
      @(negedge clk);
      if (use2) begin
        hl += int'(bus2.pwm[1]);
        hr += int'(bus2.pwm[0]);
      end else begin
        hl += int'(bus.pwm[1]);
        hr += int'(bus.pwm[0]);
      end
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d/%0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

  initial begin : main
    evt_t fwd_tbl[$], rev_tbl[$], turn_tbl[$], post_tbl[$];
    int   nbad, hl, hr, w;

    for (int k = 1; k <= 8; k++) fwd_tbl.push_back(mk(100*k, 100*k, 2'b10, 2'b10));

    for (int k = 7; k >= 0; k--) rev_tbl.push_back(mk(100*k, 100*k, 2'b10, 2'b10));
    rev_tbl.push_back(mk(0, 0, 2'b00, 2'b00));
    rev_tbl.push_back(mk(0, 0, 2'b01, 2'b01));
    for (int k = 1; k <= 7; k++) rev_tbl.push_back(mk(100*k, 100*k, 2'b01, 2'b01));
    rev_tbl.push_back(mk(750, 750, 2'b01, 2'b01));

    turn_tbl.push_back(mk(700, 750, 2'b10, 2'b10));
    for (int k = 6; k >= 0; k--) turn_tbl.push_back(mk(100*k, 750, 2'b10, 2'b10));
    turn_tbl.push_back(mk(0, 750, 2'b00, 2'b10));
    turn_tbl.push_back(mk(0, 750, 2'b01, 2'b10));
    for (int k = 1; k <= 7; k++) turn_tbl.push_back(mk(100*k, 750, 2'b01, 2'b10));
    turn_tbl.push_back(mk(750, 750, 2'b01, 2'b10));

    post_tbl.push_back(mk(0, 0, 2'b00, 2'b00));
    post_tbl.push_back(mk(0, 0, 2'b01, 2'b01));

    bus.mode  = 5'd0;
    bus2.mode = 5'd3;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 64'(outs()), 64'(RST_VEC));
    rst_n = 1'b1;

    nbad = 0;
    repeat (100) begin
      @(negedge clk);
      if (outs() !== RST_VEC) nbad++;
    end
    chk("idle_hold_bad_cycles", 64'(nbad), 64'(0));

    // Forward ramp from rest.
    sb = fwd_tbl;
    bus.mode = 5'd3;
    drain("fwd_ramp", 12);
    nbad = 0;
    for (int i = 1; i < evt_cyc.size(); i++) if (evt_cyc[i] - evt_cyc[i-1] != 4) nbad++;
    chk("fwd_tick_spacing_bad", 64'(nbad), 64'(0));
    busy_drop("fwd");

    // Full reversal: ramp down, 8-cycle coast, ramp up saturating at 750.
    sb = rev_tbl;
    bus.mode = 5'd7;
    drain("rev", 12);
    chk("rev_dead_len", 64'(evt_cyc[9] - evt_cyc[8]), 64'(8));
    busy_drop("rev");

    settle("settle_fwd1", 5'd3, mk(800, 800, 2'b10, 2'b10));

    // Left turn: only the left channel reverses.
    sb = turn_tbl;
    bus.mode = 5'd5;
    drain("left_turn", 12);
    chk("left_dead_len", 64'(evt_cyc[9] - evt_cyc[8]), 64'(8));
    busy_drop("left_turn");

    settle("settle_fwd2", 5'd3, mk(800, 800, 2'b10, 2'b10));

    repeat (1030) @(negedge clk);
    count_high(1'b0, hl, hr);
    chk("pwm800_left_high", 64'(hl), 64'(800));
    chk("pwm800_right_high", 64'(hr), 64'(800));

    // Emergency stop.
    bus.mode = 5'd31;
    @(negedge clk);
    chk("err_same_cycle", 64'(cur()), 64'(mk(0, 0, 2'b10, 2'b10)));
    nbad = 0;
    repeat (1030) begin
      @(negedge clk);
      if ({bus.pwm, bus.l_IN, bus.r_IN, bus.left_duty, bus.right_duty} !==
          {2'b00, 2'b10, 2'b10, 10'd0, 10'd0}) nbad++;
    end
    chk("err_hold_bad_cycles", 64'(nbad), 64'(0));
    sb.push_back(mk(100, 100, 2'b10, 2'b10));
    bus.mode = 5'd3;
    drain("err_restart", 8);

    // Second instance targets 512: exact 50% duty.
    chk("d512_state", 64'({bus2.left_duty, bus2.right_duty, bus2.l_IN, bus2.r_IN, bus2.busy}),
        64'({10'd512, 10'd512, 2'b10, 2'b10, 1'b0}));
    for (int win = 0; win < 2; win++) begin
      count_high(1'b1, hl, hr);
      chk($sformatf("pwm512_left_high_w%0d", win), 64'(hl), 64'(512));
      chk($sformatf("pwm512_right_high_w%0d", win), 64'(hr), 64'(512));
    end

    // Asynchronous reset in the middle of a dead time.
    settle("settle_fwd3", 5'd3, mk(800, 800, 2'b10, 2'b10));
    bus.mode = 5'd7;
    w = 0;
    while (bus.l_IN !== 2'b00 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("rst_dead_entered", 64'(bus.l_IN), 64'(2'b00));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_mid_dead", 64'(outs()), 64'(RST_VEC));
    bus.mode = 5'd0;
    @(negedge clk);
    rst_n = 1'b1;
    nbad = 0;
    repeat (20) begin
      @(negedge clk);
      if (outs() !== RST_VEC) nbad++;
    end
    chk("post_rst_idle_bad_cycles", 64'(nbad), 64'(0));
    sb = post_tbl;
    bus.mode = 5'd7;
    drain("post_rst_dead", 12);
    chk("post_rst_dead_len", 64'(evt_cyc[1] - evt_cyc[0]), 64'(8));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
